// File: rtl/cam_stream_pkg.sv
// cam_stream_pkg: shared types and constants for the camera stream transmitter.
//   - cam_state_e : frame-level FSM states
//   - PAT_*       : PATTERN_SEL codes
//   - BAR_COLOURS : RGB565 colour-bar palette, left to right
//   - CRC16-CCITT constants and byte-update helper (only with CAM_STREAM_CRC_EN)
package cam_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront
  } cam_state_e;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_FCNT    = 2'd3;

  localparam logic [15:0] BAR_COLOURS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

`ifdef CAM_STREAM_CRC_EN
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first CRC-16-CCITT update over one byte.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/cam_stream_tx_if.sv
// cam_stream_tx_if: OV7670-style pixel stream (PCLK, VSYNC, HREF, 8-bit data).
//   master : driven by the transmitter
//   slave  : observed by a receiver / monitor
interface cam_stream_tx_if;
  logic       PCLK;
  logic       CamVsync;
  logic       CamHsync;
  logic [7:0] CamData;

  modport master (output PCLK, CamVsync, CamHsync, CamData);
  modport slave  (input  PCLK, CamVsync, CamHsync, CamData);
endinterface

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: combinational RGB565 test-pattern pixel.
//   x, y      : pixel coordinates within the active window
//   sel       : PAT_BARS / PAT_RAMP / PAT_CHECKER / PAT_FCNT
//   frame_cnt : frame count latched for the current frame
//   pix       : 16-bit RGB565 pixel
module cam_pattern_gen
  import cam_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  sel,
  input  logic [7:0]  frame_cnt,
  output logic [15:0] pix
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [15:0] bar;
  logic        unused_y;

  // Only y[4] matters (checker cell size 16).
  assign unused_y = ^{y[15:5], y[3:0]};

  always_comb begin
    bar = x / 16'(BAR_W);
    if (bar > 16'd7) bar = 16'd7;
    pix = '0;
    case (sel)
      PAT_BARS:    pix = BAR_COLOURS[bar[2:0]];
      PAT_RAMP:    pix = {x[7:3], x[7:2], x[7:3]};
      PAT_CHECKER: pix = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
      PAT_FCNT:    pix = {frame_cnt, frame_cnt};
      default:     pix = '0;
    endcase
  end

endmodule

// File: rtl/cam_stream_tx.sv
// cam_stream_tx: OV7670-style camera stream transmitter driven by internal test patterns.
//   CLK, RST_N   : system clock, async active-low reset
//   EN           : stream frames continuously while high (sampled at frame boundaries)
//   PATTERN_SEL  : pattern code, latched at frame start
//   cam          : PCLK (= CLK/2), CamVsync, CamHsync (HREF), CamData (RGB565, high byte first)
//   FRAME_DONE   : one-CLK pulse after the last byte of the front porch
//   FRAME_CNT    : completed frames, wrapping
//   FRAME_CRC    : CRC-16-CCITT of the frame's active bytes (only with CAM_STREAM_CRC_EN)
// Stream outputs and counters move only on "tick" (the CLK edge where PCLK falls), so they
// are stable at PCLK rising edges.
module cam_stream_tx
  import cam_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN,
  input  logic [1:0]             PATTERN_SEL,
  cam_stream_tx_if.master        cam,
  output logic                   FRAME_DONE,
  output logic [7:0]             FRAME_CNT
`ifdef CAM_STREAM_CRC_EN
  ,
  output logic [15:0]            FRAME_CRC
`endif
);

  localparam int unsigned BX_TOTAL = 2 * (H_ACTIVE + H_BLANK);
  localparam int unsigned LY_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned BX_W     = $clog2(BX_TOTAL);
  localparam int unsigned LY_W     = $clog2(LY_TOTAL);
  localparam int unsigned Y0       = VSYNC_LINES + V_BACK;

  localparam logic [BX_W-1:0] BX_LAST        = BX_W'(BX_TOTAL - 1);
  localparam logic [BX_W-1:0] BX_HREF        = BX_W'(2 * H_ACTIVE);
  localparam logic [LY_W-1:0] LY_VSYNC_LAST  = LY_W'(VSYNC_LINES - 1);
  localparam logic [LY_W-1:0] LY_VBACK_LAST  = LY_W'(Y0 - 1);
  localparam logic [LY_W-1:0] LY_ACTIVE_LAST = LY_W'(Y0 + V_ACTIVE - 1);
  localparam logic [LY_W-1:0] LY_LAST        = LY_W'(LY_TOTAL - 1);

  cam_state_e      state_q, state_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic [LY_W-1:0] ly_q, ly_d;
  logic [1:0]      sel_q, sel_d;
  logic            pclk_q;
  logic            vsync_q, href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            frame_done_q;
  logic [7:0]      frame_cnt_q;
  logic [15:0]     pix_x, pix_y, pix;
  logic            tick, line_end, frame_end;

  assign tick      = pclk_q;
  assign line_end  = (bx_q == BX_LAST);
  assign frame_end = tick && (state_q == StVfront) && line_end && (ly_q == LY_LAST);

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    ly_d    = ly_q;
    sel_d   = sel_q;
    if (tick) begin
      if (state_q != StIdle) begin
        if (line_end) begin
          bx_d = '0;
          ly_d = (ly_q == LY_LAST) ? '0 : ly_q + 1'b1;
        end else begin
          bx_d = bx_q + 1'b1;
        end
      end
      case (state_q)
        StIdle: begin
          if (EN) begin
            state_d = StVsync;
            sel_d   = PATTERN_SEL;
          end
        end
        StVsync:  if (line_end && ly_q == LY_VSYNC_LAST) state_d = StVback;
        StVback:  if (line_end && ly_q == LY_VBACK_LAST) state_d = StActive;
        StActive: if (line_end && ly_q == LY_ACTIVE_LAST) state_d = StVfront;
        StVfront: begin
          if (frame_end) begin
            if (EN) begin
              state_d = StVsync;
              sel_d   = PATTERN_SEL;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next position so they line up with the counters.
  assign pix_x = 16'(bx_d >> 1);
  assign pix_y = 16'(ly_d) - 16'(Y0);

  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x         (pix_x),
    .y         (pix_y),
    .sel       (sel_d),
    .frame_cnt (frame_cnt_q),
    .pix       (pix)
  );

  always_comb begin
    href_d = (state_d == StActive) && (bx_d < BX_HREF);
    data_d = '0;
    if (href_d) data_d = bx_d[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      bx_q         <= '0;
      ly_q         <= '0;
      sel_q        <= '0;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      pclk_q       <= ~pclk_q;
      frame_done_q <= frame_end;
      if (tick) begin
        state_q <= state_d;
        bx_q    <= bx_d;
        ly_q    <= ly_d;
        sel_q   <= sel_d;
        vsync_q <= (state_d == StVsync);
        href_q  <= href_d;
        data_q  <= data_d;
        if (frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

`ifdef CAM_STREAM_CRC_EN
  logic [15:0] crc_q, frame_crc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= CRC_INIT;
    end else if (tick) begin
      if (frame_end) begin
        frame_crc_q <= crc_q;
        crc_q       <= CRC_INIT;
      end else if (href_d) begin
        crc_q <= crc16_ccitt_byte(crc_q, data_d);
      end
    end
  end

  assign FRAME_CRC = frame_crc_q;
`endif

  assign cam.PCLK     = pclk_q;
  assign cam.CamVsync = vsync_q;
  assign cam.CamHsync = href_q;
  assign cam.CamData  = data_q;
  assign FRAME_DONE   = frame_done_q;
  assign FRAME_CNT    = frame_cnt_q;

endmodule

// File: doc/cam_stream_tx.md
Name: cam_stream_tx

Overview:
Synthesizable OV7670-style camera pixel-stream transmitter, the sending end of the CamHsync/CamVsync/PCLK/CamData interface that VideoProc receives.
Generates PCLK, VSYNC, HREF and RGB565 bytes from internal test patterns.
Used as the camera stand-in in VideoProc benches and as an on-board self-test source when no camera is fitted.

Parameters:
H_ACTIVE, 640, active pixels per line (even, >=8)
H_BLANK, 144, blank pixel times per line (HREF low)
V_ACTIVE, 480, active lines per frame
VSYNC_LINES, 3, lines with CamVsync high
V_BACK, 17, blank lines after VSYNC, before first active line
V_FRONT, 10, blank lines after last active line

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
EN  in  1  level; 1 = stream frames continuously
PATTERN_SEL  in  2  0 colour bars, 1 ramp, 2 checker, 3 frame-count fill
PCLK  out  1  pixel-byte clock = CLK/2
CamVsync  out  1  frame sync, active high
CamHsync  out  1  HREF, high exactly during active bytes
CamData  out  8  RGB565 byte, high byte first
FRAME_DONE  out  1  one-CLK pulse after last byte of V_FRONT
FRAME_CNT  out  8  completed frames, wraps 255->0

Behaviour:
- Reset values (immediate, asynchronous): PCLK=0, CamVsync=0, CamHsync=0, CamData=0, FRAME_DONE=0, FRAME_CNT=0, state IDLE, all counters 0.
- PCLK toggles every CLK from the first cycle after reset release, independent of EN.
- Define tick = the CLK edge on which PCLK goes 1->0. All of CamVsync/CamHsync/CamData and the counters update only on tick, so they are stable on PCLK rising edges.
- Byte counter bx: 0..2*(H_ACTIVE+H_BLANK)-1. Line counter ly: 0..VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT-1. Both advance on tick in non-IDLE states. Widths via $clog2 of the totals.
- FSM:
  - IDLE: outputs low. When EN=1 at tick, go to VSYNC with bx=ly=0 and latch PATTERN_SEL.
  - VSYNC: CamVsync=1 for VSYNC_LINES full lines.
  - VBACK: lasts V_BACK lines.
  - ACTIVE: lasts V_ACTIVE lines. CamHsync=1 for bx<2*H_ACTIVE, 0 otherwise.
  - VFRONT: lasts V_FRONT lines.
- End of the VFRONT last byte: FRAME_CNT++, FRAME_DONE pulses for that CLK. Then VSYNC of the next frame if EN=1 (re-latch PATTERN_SEL), else IDLE.
- EN dropping mid-frame does not truncate; the frame always completes. PATTERN_SEL changes mid-frame are ignored.
- Pixel x = bx>>1, y = ly-(VSYNC_LINES+V_BACK). Even bx sends pix[15:8], odd bx sends pix[7:0]. CamData=0 whenever CamHsync=0.
- Patterns (pix, 16 bits):
  - 0: bar = x/(H_ACTIVE/8), colours FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
  - 1: {x[7:3],x[7:2],x[7:3]}.
  - 2: (x[4]^y[4]) ? FFFF : 0000.
  - 3: {FRAME_CNT,FRAME_CNT}, using the value latched at frame start.
- Reset asserted mid-operation: all outputs to reset values immediately. After release the generator restarts from IDLE; no partial-frame resume.

Optional Feature:
CAM_STREAM_CRC_EN
- Defined: adds output FRAME_CRC[15:0]. CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over all bytes sent with CamHsync=1. Registered into FRAME_CRC on the same CLK as FRAME_DONE; reset value 0xFFFF.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Package cam_stream_pkg: state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT), pattern-code constants, 8-entry RGB565 colour-bar constant array, CRC polynomial/init constants.
- One sub-module cam_pattern_gen: combinational pix from (x, y, sel, frame_cnt).
- Timing, FSM and byte muxing stay in cam_stream_tx.

Test Plan:
Bench parameters: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (24 ticks/line, 7 lines, 336 CLK/frame).
- Reset release, EN=0 -> PCLK toggles every CLK; CamVsync/CamHsync/CamData stay 0 for 1000 CLK.
- EN=1, sel=0 -> CamVsync high 24 ticks; then 4 HREF pulses of 16 bytes each. Line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. FRAME_DONE pulses once per 336 CLK.
- sel=3, EN held 3 frames -> active bytes 00, 01, 02 in successive frames; FRAME_CNT ends at 3.
- EN dropped during ACTIVE line 2 -> frame completes; FRAME_DONE pulses; then IDLE with outputs 0.
- RST_N low during ACTIVE -> same-cycle outputs all 0. After release, the first CamVsync rise occurs only after EN is seen at a tick.
- CAM_STREAM_CRC_EN, sel=2 -> FRAME_CRC equals the reference-model CRC of the 64 active bytes.
